axi_burst_traffic_checker: RTL and testbench
============================================

// Module: axi_burst_traffic_checker
// PURPOSE
//  Parametrised AXI4 single-ID traffic generator and checker for DDR bring-up.
//  Writes NUM_BURSTS INCR bursts of a known pattern from BASE_ADDR, then reads them back
//  and compares every beat. Counts mismatches and completed passes.
//  Sits on one DDR controller AXI slave port in the bench/bring-up top, one instance per port.
// PARAMETERS
//  DATA_W     64            AXI data width in bits; a multiple of 32.
//  ADDR_W     32            AXI address width in bits.
//  BURST_LEN  256           Beats per burst, 2..256; wlast and rlast fall on beat BURST_LEN-1.
//  NUM_BURSTS 8             Bursts per write phase and per read phase.
//  BASE_ADDR  32'h0800_0000 Address of the first burst.
//  ADDR_STEP  BURST_LEN*DATA_W/8  Address increment between consecutive bursts.
// PORTS
//  clk       in  1       Clock.
//  rstn      in  1       Asynchronous reset, active-low.
//  enable    in  1       Level. High: run passes back to back. Low: finish the current pass, then idle.
//  seed_mode in  1       0: seed=0 for every pass. 1: seed=pass_cnt. Sampled at pass start.
//  awaddr/awvalid/awready   out/out/in  ADDR_W/1/1   AXI write address channel.
//  wdata/wlast/wvalid/wready out/out/out/in DATA_W/1/1/1 AXI write data channel.
//  araddr/arvalid/arready   out/out/in  ADDR_W/1/1   AXI read address channel.
//  rdata/rlast/rvalid/rready in/in/in/out DATA_W/1/1/1 AXI read data channel.
//  busy      out 1       High in any state other than IDLE.
//  done      out 1       One-cycle pulse when the last read beat of a pass is accepted.
//  err       out 1       Sticky. Set on the first mismatch; cleared only by reset.
//  err_cnt   out 16      Mismatching beats plus rlast violations; saturates at 16'hFFFF.
//  pass_cnt  out 16      Completed passes; wraps modulo 2^16.
// BEHAVIOUR
//  Reset: every output is 0 and all internal counters are 0. Reset is asynchronous and
//   aborts any transfer at once, including mid-burst. awlen, awsize and awburst are fixed
//   in the wrapper and are not ports here.
//  Pattern: for global beat index i = b*BURST_LEN + k, where b is the burst and k the beat:
//   wdata = {DATA_W/32{i + seed}}, with the 32-bit sum wrapping.
//  FSM states: IDLE, AW, W, AR, R.
//   IDLE -> AW when enable=1. Latch the seed, set b=0.
//   AW: awvalid=1 and awaddr=BASE_ADDR+b*ADDR_STEP, held stable until awready.
//     On the handshake go to W.
//   W: wvalid=1 continuously. wdata advances and k increments only on wvalid&wready.
//     wlast=1 exactly while k==BURST_LEN-1.
//     On the last handshake: if b<NUM_BURSTS-1 then b++ and go to AW;
//     otherwise b=0 and go to AR.
//   AR: arvalid=1 and araddr=BASE_ADDR+b*ADDR_STEP, held stable until arready.
//     On the handshake go to R.
//   R: rready=1. On each rvalid&rready, compare rdata with the expected pattern.
//     Mismatch: err_cnt+1 (saturating) and err<=1.
//     rlast at k!=BURST_LEN-1, or rlast missing at k==BURST_LEN-1: err_cnt+1 as well.
//     If both occur on one beat, err_cnt takes a single +1.
//     The burst ends on the beat with k==BURST_LEN-1, regardless of rlast.
//     Last beat of the last burst: pass_cnt++, done pulse, then AW if enable=1 else IDLE.
//  AW and W never overlap, and AR and R never overlap; the block issues one outstanding
//   transaction at a time.
//  Address wrap: the address arithmetic is ADDR_W wide and wraps silently.
//  When enable falls mid-pass, the pass completes; enable is checked only at the end of a pass.
//  Latency: awvalid rises 1 clk after IDLE sees enable=1. done is registered and rises
//   1 clk after the final read handshake.
// TESTING
//  1. Ideal slave (all ready=1, memory model), defaults, enable pulsed for 1 clk ->
//     8 AW at 0x0800_0000..0x0800_3800, 2048 W beats, done once, err_cnt=0, pass_cnt=1.
//  2. Random awready/wready/arready/rvalid backpressure (50%) -> wdata/awaddr held stable
//     while stalled, 2048 beats each way, err_cnt=0.
//  3. Memory model flips bit 0 of read beat 300 -> err=1 and err_cnt=1;
//     inject again on the next pass -> err_cnt=2.
//  4. Slave drives rlast on beat 100 of burst 2 -> err_cnt=1, and the burst still ends at beat 255.
//  5. seed_mode=1, enable held for 3 passes -> the first beat of pass 2 has wdata=64'h00000002_00000002;
//     pass_cnt=3; done pulses 3 times.
//  6. Assert rstn low mid W burst, then release -> all outputs 0 at once; the next enable
//     restarts from 0x0800_0000.

Source files
------------

// File: rtl/axi_burst_traffic_checker.sv
// AXI4 single-ID burst traffic generator/checker: writes a known pattern burst by burst,
// reads it back, and counts mismatching beats and rlast violations.
module axi_burst_traffic_checker #(
    parameter int unsigned        DATA_W     = 64,
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        BURST_LEN  = 256,
    parameter int unsigned        NUM_BURSTS = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = ADDR_W'(32'h0800_0000),
    parameter int unsigned        ADDR_STEP  = BURST_LEN * DATA_W / 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              seed_mode,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       err_cnt,
    output logic [15:0]       pass_cnt
);

    localparam int unsigned BeatW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned BurstW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BeatW-1:0]  LastBeat  = BeatW'(BURST_LEN - 1);
    localparam logic [BurstW-1:0] LastBurst = BurstW'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {StIdle, StAw, StW, StAr, StR} state_e;

    state_e            state_q, state_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [31:0]       seed_q, seed_d;
    logic [15:0]       pass_cnt_q, pass_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic [31:0]       pattern;
    logic [DATA_W-1:0] exp_data;
    logic [ADDR_W-1:0] burst_addr;
    logic              last_beat, last_burst, mismatch, rlast_bad;

    // Global beat index within the pass, offset by the pass seed; 32-bit wrap is intended.
    assign pattern    = 32'(burst_q) * 32'(BURST_LEN) + 32'(beat_q) + seed_q;
    assign exp_data   = {(DATA_W / 32){pattern}};
    assign burst_addr = BASE_ADDR + ADDR_W'(burst_q) * ADDR_W'(ADDR_STEP);
    assign last_beat  = (beat_q == LastBeat);
    assign last_burst = (burst_q == LastBurst);
    assign mismatch   = (rdata != exp_data);
    assign rlast_bad  = (rlast != last_beat);

    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        beat_d     = beat_q;
        seed_d     = seed_q;
        pass_cnt_d = pass_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_d      = err_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    seed_d  = seed_mode ? 32'(pass_cnt_q) : 32'd0;
                    burst_d = '0;
                    beat_d  = '0;
                    state_d = StAw;
                end
            end
            StAw: begin
                if (awready) state_d = StW;
            end
            StW: begin
                if (wready) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (last_burst) begin
                            burst_d = '0;
                            state_d = StAr;
                        end else begin
                            burst_d = burst_q + BurstW'(1);
                            state_d = StAw;
                        end
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            StAr: begin
                if (arready) state_d = StR;
            end
            StR: begin
                if (rvalid) begin
                    // A data error and an rlast error on the same beat count once.
                    if ((mismatch || rlast_bad) && err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (mismatch) err_d = 1'b1;
                    if (last_beat) begin
                        beat_d = '0;
                        if (last_burst) begin
                            burst_d    = '0;
                            pass_cnt_d = pass_cnt_q + 16'd1;
                            done_d     = 1'b1;
                            if (enable) begin
                                seed_d  = seed_mode ? 32'(pass_cnt_q + 16'd1) : 32'd0;
                                state_d = StAw;
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            burst_d = burst_q + BurstW'(1);
                            state_d = StAr;
                        end
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            burst_q    <= '0;
            beat_q     <= '0;
            seed_q     <= '0;
            pass_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            beat_q     <= beat_d;
            seed_q     <= seed_d;
            pass_cnt_q <= pass_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    // Address and data are forced to zero outside their phase so idle outputs are all zero.
    assign awvalid  = (state_q == StAw);
    assign awaddr   = awvalid ? burst_addr : '0;
    assign wvalid   = (state_q == StW);
    assign wdata    = wvalid ? exp_data : '0;
    assign wlast    = wvalid && last_beat;
    assign arvalid  = (state_q == StAr);
    assign araddr   = arvalid ? burst_addr : '0;
    assign rready   = (state_q == StR);
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_axi_burst_traffic_checker.sv
// Bench for axi_burst_traffic_checker: AXI slave with memory, transaction-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_axi_burst_traffic_checker;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 32;
    localparam int unsigned BL = 256;
    localparam int unsigned NB = 8;
    localparam logic [31:0] BASE = 32'h0800_0000;
    localparam logic [31:0] STEP = 32'(BL * DW / 8);

    logic          clk, rstn, enable, seed_mode;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wlast, wvalid, wready, arvalid, arready;
    logic [DW-1:0] wdata, rdata;
    logic          rlast, rvalid, rready, busy, done, err;
    logic [15:0]   err_cnt, pass_cnt;

    axi_burst_traffic_checker #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .BURST_LEN (BL),
        .NUM_BURSTS(NB),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .seed_mode(seed_mode),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wlast    (wlast),
        .wvalid   (wvalid),
        .wready   (wready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .rready   (rready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_cnt  (err_cnt),
        .pass_cnt (pass_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Stimulus knobs (main process)
    logic bp = 1'b0;
    int   inj_flip = -1;
    int   inj_rlast = -1;

    // Model and slave state (monitor process)
    logic [63:0] mem [logic [31:0]];
    int          m_aw, m_wb, m_ar, m_rb;
    logic [15:0] m_pass, m_errc;
    logic        m_err, m_active, m_done_exp;
    logic [31:0] m_seed;
    logic [31:0] waddr, raddr;
    int          wk, rk;
    logic        r_pend;
    int          tot_aw, tot_w, tot_ar, tot_r, done_cnt;
    logic [31:0] first_aw, last_aw;
    logic [63:0] cap_w;

    function automatic logic [63:0] pat(input int idx, input logic [31:0] seed);
        logic [31:0] v;
        v = 32'(idx) + seed;
        return {v, v};
    endfunction

    initial begin
        logic [63:0] exp_r;
        logic        bad_d, bad_l, done_n, active_n;
        bit          c_aw, c_w, c_ar, c_r;
        awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0; rlast = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin
                m_aw = 0; m_wb = 0; m_ar = 0; m_rb = 0; m_pass = 0; m_errc = 0;
                m_err = 0; m_active = 0; m_done_exp = 0; m_seed = 0;
                wk = 0; rk = 0; r_pend = 0; waddr = 0; raddr = 0;
                tot_aw = 0; tot_w = 0; tot_ar = 0; tot_r = 0; done_cnt = 0;
                first_aw = 0; last_aw = 0; cap_w = 0;
                awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0; rlast = 0;
                continue;
            end
            // Which channel must be active, derived from transaction counts alone
            c_aw = 0; c_w = 0; c_ar = 0; c_r = 0;
            if (m_active) begin
                if (m_wb == m_aw * BL && m_aw < NB) c_aw = 1;
                else if (m_wb < m_aw * BL)          c_w = 1;
                else if (m_rb == m_ar * BL)         c_ar = 1;
                else                                c_r = 1;
            end
            check("awvalid", awvalid, c_aw);
            check("wvalid", wvalid, c_w);
            check("arvalid", arvalid, c_ar);
            check("rready", rready, c_r);
            check("busy", busy, m_active);
            check("wlast", wlast, c_w && (m_wb % BL == BL - 1));
            check("done", done, m_done_exp);
            check("err", err, m_err);
            check("err_cnt", err_cnt, m_errc);
            check("pass_cnt", pass_cnt, m_pass);
            if (c_aw) check("awaddr", awaddr, BASE + 32'(m_aw) * STEP);
            if (c_w)  check("wdata", wdata, pat(m_wb, m_seed));
            if (c_ar) check("araddr", araddr, BASE + 32'(m_ar) * STEP);
            if (done === 1'b1) done_cnt++;

            awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            arready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (r_pend && (!bp || $urandom_range(0, 1) == 1)) begin
                rvalid = 1;
                rdata  = mem.exists(raddr + 32'(rk * 8)) ? mem[raddr + 32'(rk * 8)] : 64'h0;
                if (m_rb == inj_flip) rdata = rdata ^ 64'h1;
                rlast  = (rk == BL - 1) || (m_rb == inj_rlast);
            end else begin
                rvalid = 0; rdata = '0; rlast = 0;
            end
            #1;
            done_n   = 0;
            active_n = m_active;
            if (!m_active && enable) begin
                active_n = 1;
                m_seed   = seed_mode ? {16'h0, m_pass} : 32'h0;
            end
            if (awvalid && awready) begin
                if (tot_aw == 0) first_aw = awaddr;
                last_aw = awaddr; waddr = awaddr; wk = 0;
                m_aw++; tot_aw++;
            end
            if (wvalid && wready) begin
                if (m_wb == 0 && m_pass == 16'd2) cap_w = wdata;
                mem[waddr + 32'(wk * 8)] = wdata;
                wk++; m_wb++; tot_w++;
            end
            if (arvalid && arready) begin
                raddr = araddr; rk = 0; r_pend = 1;
                m_ar++; tot_ar++;
            end
            if (rvalid && rready) begin
                exp_r = pat(m_rb, m_seed);
                bad_d = (rdata !== exp_r);
                bad_l = (rlast !== (m_rb % BL == BL - 1));
                if ((bad_d || bad_l) && m_errc != 16'hFFFF) m_errc++;
                if (bad_d) m_err = 1;
                rk++;
                if (rk == BL) r_pend = 0;
                m_rb++; tot_r++;
                if (m_rb == NB * BL) begin
                    m_pass++;
                    done_n = 1;
                    m_aw = 0; m_wb = 0; m_ar = 0; m_rb = 0;
                    active_n = enable;
                    if (enable) m_seed = seed_mode ? {16'h0, m_pass} : 32'h0;
                end
            end
            m_done_exp = done_n;
            m_active   = active_n;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #3 rstn = 0;
        repeat (2) @(negedge clk);
        rstn = 1;
    endtask

    task automatic pulse_enable();
        @(negedge clk);
        enable = 1;
        @(negedge clk);
        enable = 0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int i = 0;
        while (done_cnt < target && i < budget) begin
            @(negedge clk);
            #2;
            i++;
        end
        check("wait_done", 64'(done_cnt), 64'(target));
    endtask

    initial begin
        rstn = 0; enable = 0; seed_mode = 0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_outs", {awvalid, wvalid, wlast, arvalid, rready, busy, done, err}, 8'h0);
        check("rst_cnts", {err_cnt, pass_cnt}, 32'h0);
        check("rst_addr", {awaddr, araddr}, 64'h0);
        @(negedge clk);
        rstn = 1;

        // 1: ideal slave, single pass
        pulse_enable();
        wait_done(1, 10000);
        repeat (2) @(negedge clk);
        #2;
        check("t1_aw_cnt", 64'(tot_aw), 64'd8);
        check("t1_first_aw", first_aw, 32'h0800_0000);
        check("t1_last_aw", last_aw, 32'h0800_3800);
        check("t1_w_beats", 64'(tot_w), 64'd2048);
        check("t1_r_beats", 64'(tot_r), 64'd2048);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_err_cnt", err_cnt, 16'd0);
        check("t1_pass_cnt", pass_cnt, 16'd1);
        check("t1_idle", busy, 1'b0);

        // 2: random backpressure on every channel
        do_reset();
        bp = 1;
        pulse_enable();
        wait_done(1, 40000);
        bp = 0;
        repeat (2) @(negedge clk);
        #2;
        check("t2_w_beats", 64'(tot_w), 64'd2048);
        check("t2_r_beats", 64'(tot_r), 64'd2048);
        check("t2_err_cnt", err_cnt, 16'd0);

        // 3: flip bit 0 of read beat 300, two passes
        do_reset();
        inj_flip = 300;
        pulse_enable();
        wait_done(1, 10000);
        #2;
        check("t3_err", err, 1'b1);
        check("t3_err_cnt1", err_cnt, 16'd1);
        pulse_enable();
        wait_done(2, 10000);
        #2;
        check("t3_err_cnt2", err_cnt, 16'd2);
        check("t3_pass_cnt", pass_cnt, 16'd2);
        inj_flip = -1;

        // 4: early rlast at beat 100 of burst 2
        do_reset();
        inj_rlast = 2 * 256 + 100;
        pulse_enable();
        wait_done(1, 10000);
        #2;
        check("t4_err_cnt", err_cnt, 16'd1);
        check("t4_ar_cnt", 64'(tot_ar), 64'd8);
        check("t4_r_beats", 64'(tot_r), 64'd2048);
        inj_rlast = -1;

        // 5: seed_mode=1, three passes back to back
        do_reset();
        seed_mode = 1;
        @(negedge clk);
        enable = 1;
        wait_done(2, 20000);
        enable = 0;
        wait_done(3, 10000);
        repeat (2) @(negedge clk);
        #2;
        check("t5_pass_cnt", pass_cnt, 16'd3);
        check("t5_done_cnt", 64'(done_cnt), 64'd3);
        check("t5_pass2_w0", cap_w, 64'h00000002_00000002);
        check("t5_err_cnt", err_cnt, 16'd0);
        check("t5_idle", busy, 1'b0);
        seed_mode = 0;

        // 6: asynchronous reset in the middle of a W burst
        begin
            int i = 0;
            pulse_enable();
            while (!(wvalid && tot_w >= 40) && i < 5000) begin
                @(negedge clk);
                #2;
                i++;
            end
            check("t6_reach_w", 64'(wvalid && tot_w >= 40), 64'd1);
        end
        @(negedge clk);
        #3 rstn = 0;
        #1;
        check("t6_rst_outs", {awvalid, wvalid, wlast, arvalid, rready, busy, done, err}, 8'h0);
        check("t6_rst_cnts", {err_cnt, pass_cnt}, 32'h0);
        check("t6_rst_data", wdata, 64'h0);
        repeat (2) @(negedge clk);
        rstn = 1;
        pulse_enable();
        wait_done(1, 10000);
        #2;
        check("t6_first_aw", first_aw, 32'h0800_0000);
        check("t6_pass_cnt", pass_cnt, 16'd1);
        check("t6_w_beats", 64'(tot_w), 64'd2048);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
